// File: rtl/dz_rxscan.sv
// dz_rxscan - receiver scanner and silo for a DZ-11 style line multiplexer.
//
// Polls the receive-full flags of LINES UART receivers round-robin while
// master scan is enabled. Each captured character is packed with its line
// number and error flags and written into a DEPTH-entry silo. The receiver
// flag of that line is then cleared with a one-cycle pulse. The silo head is
// presented on rbufDATA and popped by rbufREAD. RDONE and the silo alarm feed
// the CSR.
//
// Ports:
//   clk       clock
//   rst       synchronous reset, active low
//   clr       synchronous clear, active high (same effect as reset)
//   mse       master scan enable
//   sae       silo alarm enable
//   rxfull    per-line receiver-full flags
//   rxdata    per-line received character, line n at [8n+7:8n]
//   rxpare    per-line parity error
//   rxfrme    per-line framing error
//   rxclr     per-line receiver-flag clear, one-cycle pulse
//   rbufREAD  RBUF read strobe, pops the silo head
//   rbufDATA  {DVAL, OVRN, FRME, PARE, 0, line[2:0], char[7:0]}
//   rdone     silo not empty
//   salarm    silo alarm
module dz_rxscan #(
    parameter int LINES = 8,
    parameter int DEPTH = 64,
    parameter int ALARM = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 mse,
    input  logic                 sae,
    input  logic [LINES-1:0]     rxfull,
    input  logic [8*LINES-1:0]   rxdata,
    input  logic [LINES-1:0]     rxpare,
    input  logic [LINES-1:0]     rxfrme,
    output logic [LINES-1:0]     rxclr,
    input  logic                 rbufREAD,
    output logic [15:0]          rbufDATA,
    output logic                 rdone,
    output logic                 salarm
);

    localparam int LW = (LINES > 1) ? $clog2(LINES) : 1;
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(ALARM + 1);
    localparam logic [AW:0]   FULL_C  = (AW+1)'(DEPTH);
    localparam logic [CW-1:0] ALARM_C = CW'(ALARM);

    typedef enum logic [1:0] {
        ST_SCAN = 2'd0,
        ST_CAPT = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t            state_reg, state_next;
    logic [LW-1:0]     ptr_reg, ptr_next;
    logic [AW:0]       count_reg, count_next;
    logic [AW-1:0]     head_reg, head_next;
    logic [AW-1:0]     tail_reg, tail_next;
    logic              ovrn_reg, ovrn_next;
    logic [CW-1:0]     alarm_reg, alarm_next;
    logic [15:0]       rbuf_reg, rbuf_next;
    logic              rdone_reg;
    logic              salarm_reg;

    // Silo storage: {OVRN, FRME, PARE, 0, line, char}
    logic [14:0]       mem [DEPTH];

    logic              capt;
    logic              wr;
    logic              pop;
    logic              fwd;
    logic [AW:0]       count_after_pop;
    logic [14:0]       wdata;
    logic [2:0]        line_field;
    logic [7:0]        line_char [LINES];

    genvar gi;
    generate
        for (gi = 0; gi < LINES; gi++) begin : g_line
            assign line_char[gi] = rxdata[8*gi +: 8];
        end
    endgenerate

    assign line_field = 3'(ptr_reg);
    assign wdata      = {ovrn_reg, rxfrme[ptr_reg], rxpare[ptr_reg], 1'b0,
                         line_field, line_char[ptr_reg]};

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (!rst || clr) begin
            state_reg <= ST_SCAN;
        end else begin
            state_reg <= state_next;
        end
    end

    // ---------------- FSM: next state and scan pointer ----------------
    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        case (state_reg)
            ST_SCAN: begin
                if (mse) begin
                    if (rxfull[ptr_reg]) begin
                        state_next = ST_CAPT;
                    end else begin
                        ptr_next = ptr_reg + LW'(1);
                    end
                end
            end
            // Capture completes regardless of mse.
            ST_CAPT: state_next = ST_WAIT;
            // Give rxfull a cycle to fall, then resume at the next line.
            ST_WAIT: begin
                state_next = ST_SCAN;
                ptr_next   = ptr_reg + LW'(1);
            end
            default: state_next = ST_SCAN;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        rxclr = '0;
        capt  = 1'b0;
        if (state_reg == ST_CAPT) begin
            capt           = 1'b1;
            rxclr[ptr_reg] = 1'b1;
        end
    end

    // ---------------- silo control ----------------
    // A pop in the same cycle frees a slot, so a full silo still accepts.
    assign pop             = rbufREAD && (count_reg != '0);
    assign wr              = capt && ((count_reg != FULL_C) || pop);
    assign count_after_pop = count_reg - (AW+1)'(pop);
    // The written entry becomes the head when the silo is empty after the pop.
    assign fwd             = wr && (count_after_pop == '0);

    always_comb begin
        head_next  = head_reg;
        tail_next  = tail_reg;
        count_next = count_reg;
        ovrn_next  = ovrn_reg;
        alarm_next = alarm_reg;
        rbuf_next  = '0;

        if (pop) begin
            head_next = head_reg + AW'(1);
        end
        if (wr) begin
            tail_next = tail_reg + AW'(1);
        end
        if (wr && !pop) begin
            count_next = count_reg + (AW+1)'(1);
        end else if (pop && !wr) begin
            count_next = count_reg - (AW+1)'(1);
        end

        if (wr) begin
            ovrn_next = 1'b0;
        end else if (capt) begin
            ovrn_next = 1'b1;
        end

        if (pop) begin
            alarm_next = wr ? CW'(1) : '0;
        end else if (wr && (alarm_reg != ALARM_C)) begin
            alarm_next = alarm_reg + CW'(1);
        end

        // rbufDATA is registered from the head the silo will have next cycle.
        if (count_next != '0) begin
            rbuf_next = {1'b1, fwd ? wdata : mem[head_next]};
        end
    end

    always_ff @(posedge clk) begin
        if (wr) begin
            mem[tail_reg] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst || clr) begin
            ptr_reg    <= '0;
            count_reg  <= '0;
            head_reg   <= '0;
            tail_reg   <= '0;
            ovrn_reg   <= 1'b0;
            alarm_reg  <= '0;
            rbuf_reg   <= '0;
            rdone_reg  <= 1'b0;
            salarm_reg <= 1'b0;
        end else begin
            ptr_reg    <= ptr_next;
            count_reg  <= count_next;
            head_reg   <= head_next;
            tail_reg   <= tail_next;
            ovrn_reg   <= ovrn_next;
            alarm_reg  <= alarm_next;
            rbuf_reg   <= rbuf_next;
            rdone_reg  <= (count_next != '0);
            salarm_reg <= sae && (alarm_next == ALARM_C);
        end
    end

    assign rbufDATA = rbuf_reg;
    assign rdone    = rdone_reg;
    assign salarm   = salarm_reg;

endmodule
